// File: rtl/ehl_tech_pkg.sv
// Technology encodings shared by the ehl_* buffer family, plus a constant-safe
// ceiling-log2 used to size occupancy and pointer fields.
package ehl_tech_pkg;

  localparam int TECH_RTL  = 0;  // generic behavioural logic
  localparam int TECH_CELL = 1;  // first vendor-mapped cell library

  // Smallest r such that 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ehl_buf.sv
// Single-bit output buffer cell; TECHNOLOGY selects generic logic or the mapped cell.
module ehl_buf
  import ehl_tech_pkg::*;
#(
  parameter int TECHNOLOGY = TECH_RTL
) (
  input  logic a,
  output logic y
);

  generate
    if (TECHNOLOGY == TECH_RTL) begin : g_rtl
      assign y = a;
    end else begin : g_cell
      // Gate primitive stands in for the vendor buffer so both flavours simulate identically.
      buf u_cell (y, a);
    end
  endgenerate

endmodule

// File: rtl/ehl_buf_fifo.sv
// DEPTH-entry elastic FIFO with valid/ready on both sides, occupancy and flush.
// All outputs come from registered state and leave through ehl_buf cells.
module ehl_buf_fifo
  import ehl_tech_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 2,
  parameter  int TECHNOLOGY = TECH_RTL,
  localparam int LW         = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [LW-1:0]    level_o
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [WIDTH-1:0] last_pop;

  logic             not_full;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_data;

  // Explicit wrap keeps non-power-of-2 depths inside the storage array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign not_full  = (count != LW'(DEPTH));
  assign not_empty = (count != '0);
  assign push      = valid_i & not_full;
  assign pop       = not_empty & ready_i;

  // An empty queue keeps presenting the word that left last, not stale storage.
  assign head_data = not_empty ? mem[rd_ptr] : last_pop;

  // NOTE: storage is cleared on reset/flush because the head mux can expose any entry;
  // every state element here is sequential, so only non-blocking assignments are used.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_pop <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        last_pop <= mem[rd_ptr];
        rd_ptr   <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_data_buf
    ehl_buf #(.TECHNOLOGY(TECHNOLOGY)) u_buf (.a(head_data[b]), .y(data_o[b]));
  end

  for (genvar b = 0; b < LW; b++) begin : g_level_buf
    ehl_buf #(.TECHNOLOGY(TECHNOLOGY)) u_buf (.a(count[b]), .y(level_o[b]));
  end

  ehl_buf #(.TECHNOLOGY(TECHNOLOGY)) u_valid_buf (.a(not_empty), .y(valid_o));
  ehl_buf #(.TECHNOLOGY(TECHNOLOGY)) u_ready_buf (.a(not_full),  .y(ready_o));

endmodule
